// File: rtl/char_ram_line_reader.sv
// ---------------------------------------------------------------------------
// char_ram_line_reader
//
// Read-side consumer of the text-mode character RAM. During horizontal
// blanking of the last pixel line of a text row it copies the next row of
// character codes into a local line buffer. During active video it turns
// the buffered codes into pixels through the font ROM. Each text cell is
// 8x16 pixels and cell (row, col) lives at address row*COLS + col.
//
// Optional feature macro: CHAR_RAM_READER_BGBOX_EN
//   defined   : a visible, non-blank cell draws 8'h20 where its glyph bit is 0
//   undefined : those pixels are 0 (transparent)
//
// Ports
//   clock50MHz      in   1  system clock
//   resetn          in   1  synchronous, active-low reset
//   xOrd            in  10  pixel column
//   yOrd            in  10  pixel line
//   visible         in   1  active video
//   charRamAddrB    out 13  character RAM read address (1-cycle read latency)
//   charRamDataRdB  in   7  character RAM read data
//   fontAddr        out 11  font ROM address {code, glyphRow} (1-cycle latency)
//   fontRowData     in   8  font ROM row, bit 7 = leftmost pixel
//   pixelR/G/B      out  8  text colour; 0 means transparent downstream
//   fetchBusy       out  1  line fetch in progress (FETCH or DRAIN)
//
// Handshake: there is no valid/ready pair. A fetch starts on the rising edge
// of the trigger condition while IDLE; a trigger seen while busy is dropped.
// Pixels appear exactly two clocks after the xOrd/yOrd/visible that made them.
// ---------------------------------------------------------------------------
module char_ram_line_reader #(
  parameter int COLS     = 80,
  parameter int ROWS     = 30,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525
) (
  input  logic        clock50MHz,
  input  logic        resetn,
  input  logic [9:0]  xOrd,
  input  logic [9:0]  yOrd,
  input  logic        visible,
  output logic [12:0] charRamAddrB,
  input  logic [6:0]  charRamDataRdB,
  output logic [10:0] fontAddr,
  input  logic [7:0]  fontRowData,
  output logic [7:0]  pixelR,
  output logic [7:0]  pixelG,
  output logic [7:0]  pixelB,
  output logic        fetchBusy
);

  localparam logic [9:0]  H_ACTIVE_L   = 10'(H_ACTIVE);
  localparam logic [9:0]  LAST_TXT_LN  = 10'(16 * ROWS - 1);
  localparam logic [9:0]  LAST_FRM_LN  = 10'(V_TOTAL - 1);
  localparam logic [6:0]  COLS_L7      = 7'(COLS);
  localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
  localparam logic [12:0] COLS_L13     = 13'(COLS);

`ifdef CHAR_RAM_READER_BGBOX_EN
  localparam logic [7:0]  BG_LEVEL     = 8'h20;
`else
  localparam logic [7:0]  BG_LEVEL     = 8'h00;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Fetch control
  // ---------------------------------------------------------------------
  state_t      state_q;
  logic [6:0]  col_q;
  logic [12:0] addr_q;
  logic        busy_q;
  logic        line_valid_q;
  logic        trig_cond_q;
  logic        wr_en_q;
  logic [6:0]  wr_idx_q;

  logic        trig_cond;
  logic        trig_fire;
  logic [5:0]  next_row;
  logic [12:0] start_addr;

  // Last pixel line of a text row (not the final one) loads the next row;
  // the last line of the frame loads row 0 for the next frame.
  assign trig_cond = (xOrd == H_ACTIVE_L) &&
                     (((yOrd[3:0] == 4'hF) && (yOrd < LAST_TXT_LN)) ||
                      (yOrd == LAST_FRM_LN));

  // Firing on the rising edge keeps it to one fetch per line even when
  // xOrd dwells on H_ACTIVE for several system clocks.
  assign trig_fire  = trig_cond && !trig_cond_q;
  assign next_row   = 6'((yOrd + 10'd1) >> 4);
  assign start_addr = (yOrd == LAST_FRM_LN) ? 13'd0
                                            : ({7'd0, next_row} * COLS_L13);

  always_ff @(posedge clock50MHz) begin
    if (!resetn) begin
      state_q      <= IDLE;
      col_q        <= 7'd0;
      addr_q       <= 13'd0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
      trig_cond_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= 7'd0;
    end else begin
      trig_cond_q <= trig_cond;
      // Data for the address shown this cycle returns next cycle; the write
      // strobe follows the address by one clock to line up with it.
      wr_en_q     <= (state_q == FETCH);
      wr_idx_q    <= col_q;
      case (state_q)
        IDLE: begin
          if (trig_fire) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            addr_q  <= start_addr;
            col_q   <= 7'd0;
          end
        end
        FETCH: begin
          if (col_q == LAST_COL) begin
            state_q <= DRAIN;
          end else begin
            col_q  <= col_q + 7'd1;
            addr_q <= addr_q + 13'd1;
          end
        end
        DRAIN: begin
          // The last byte is written this cycle via wr_en_q.
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          line_valid_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign charRamAddrB = addr_q;
  assign fetchBusy    = busy_q;

  // ---------------------------------------------------------------------
  // Line buffer (contents are not reset; line_valid_q qualifies them)
  // ---------------------------------------------------------------------
  logic [6:0] line_buf [0:COLS-1];

  always_ff @(posedge clock50MHz) begin
    if (wr_en_q) begin
      line_buf[wr_idx_q] <= charRamDataRdB;
    end
  end

  // ---------------------------------------------------------------------
  // Render pipeline
  //   stage 1: code lookup, registered fontAddr
  //   stage 2: font ROM data returns; pixel is picked from it directly
  // ---------------------------------------------------------------------
  logic [6:0]  col_idx;
  logic        col_in_range;
  logic [6:0]  code_d;

  logic [6:0]  code_q;
  logic [2:0]  bit_sel_q;
  logic        vis_q;
  logic [10:0] font_addr_q;

  logic        show2_q;
  logic [2:0]  bit_sel2_q;
  logic        show_d;
  logic [7:0]  pix_d;

  assign col_idx      = xOrd[9:3];
  assign col_in_range = (col_idx < COLS_L7);
  // Columns past the text area read as blank code 0, which renders clear.
  assign code_d       = col_in_range ? line_buf[col_idx] : 7'd0;

  always_ff @(posedge clock50MHz) begin
    if (!resetn) begin
      code_q      <= 7'd0;
      bit_sel_q   <= 3'd0;
      vis_q       <= 1'b0;
      font_addr_q <= 11'd0;
      show2_q     <= 1'b0;
      bit_sel2_q  <= 3'd0;
    end else begin
      code_q      <= code_d;
      bit_sel_q   <= xOrd[2:0];
      vis_q       <= visible;
      font_addr_q <= {code_d, yOrd[3:0]};
      show2_q     <= show_d;
      bit_sel2_q  <= bit_sel_q;
    end
  end

  // Codes 0 and 32 (space) are blank cells and never draw, not even a box.
  assign show_d = vis_q && line_valid_q && (code_q != 7'd0) && (code_q != 7'd32);

  always_comb begin
    pix_d = 8'h00;
    if (show2_q) begin
      pix_d = fontRowData[3'd7 - bit_sel2_q] ? 8'hFF : BG_LEVEL;
    end
  end

  assign fontAddr = font_addr_q;
  assign pixelR   = pix_d;
  assign pixelG   = pix_d;
  assign pixelB   = pix_d;

endmodule

// File: tb/tb_char_ram_line_reader.sv
// ---------------------------------------------------------------------------
// tb_char_ram_line_reader
//
// Bench for char_ram_line_reader with behavioural models of the character
// RAM (random contents plus a few fixed cells) and the font ROM (a fixed
// function of the address). Expected addresses and pixels are queued when
// stimulus is driven and popped when the design produces them.
// ---------------------------------------------------------------------------
module tb_char_ram_line_reader;

  logic        clock50MHz = 1'b0;
  logic        resetn;
  logic [9:0]  xOrd;
  logic [9:0]  yOrd;
  logic        visible;
  logic [12:0] charRamAddrB;
  logic [6:0]  charRamDataRdB;
  logic [10:0] fontAddr;
  logic [7:0]  fontRowData;
  logic [7:0]  pixelR;
  logic [7:0]  pixelG;
  logic [7:0]  pixelB;
  logic        fetchBusy;

`ifdef CHAR_RAM_READER_BGBOX_EN
  localparam logic [7:0] BG = 8'h20;
`else
  localparam logic [7:0] BG = 8'h00;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [6:0]  mem [0:8191];
  logic [6:0]  exp_line [0:79];
  logic        exp_lv;
  logic [12:0] last_addr;

  logic [12:0] addr_q [$];
  logic [23:0] pix_q [$];
  logic [11:0] fa_q [$];

  char_ram_line_reader dut (
    .clock50MHz     (clock50MHz),
    .resetn         (resetn),
    .xOrd           (xOrd),
    .yOrd           (yOrd),
    .visible        (visible),
    .charRamAddrB   (charRamAddrB),
    .charRamDataRdB (charRamDataRdB),
    .fontAddr       (fontAddr),
    .fontRowData    (fontRowData),
    .pixelR         (pixelR),
    .pixelG         (pixelG),
    .pixelB         (pixelB),
    .fetchBusy      (fetchBusy)
  );

  // ---------------- clock / reset ----------------
  always #10 clock50MHz = ~clock50MHz;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- memory models ----------------
  function automatic logic [7:0] font_fn(input logic [10:0] a);
    if (a == 11'h303) return 8'h3C;   // code 48 ('0'), glyph row 3
    return a[7:0] ^ {a[10:4], 1'b1};
  endfunction

  always @(posedge clock50MHz) begin
    charRamDataRdB <= mem[charRamAddrB];
    fontRowData    <= font_fn(fontAddr);
  end

  // ---------------- reference pixel model ----------------
  function automatic logic [23:0] exp_pixel(input logic [9:0] x, input logic [9:0] y,
                                            input logic vis);
    int         col;
    int         b;
    logic [6:0] code;
    logic [7:0] f;
    col = int'(x) / 8;
    if (!vis || !exp_lv || col >= 80) return 24'h0;
    code = exp_line[col];
    if (code == 7'd0 || code == 7'd32) return 24'h0;
    f = font_fn({code, y[3:0]});
    b = 7 - int'(x[2:0]);
    if (f[b]) return 24'hFFFFFF;
    return {BG, BG, BG};
  endfunction

  task automatic step();
    @(posedge clock50MHz);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn  = 1'b0;
    xOrd    = 10'd0;
    yOrd    = 10'd0;
    visible = 1'b0;
    repeat (3) step();
    total_cnt++;
    if (fetchBusy !== 1'b0) $display("FAIL reset_busy: got %0h expected 0", fetchBusy);
    else pass_cnt++;
    total_cnt++;
    if (charRamAddrB !== 13'd0) $display("FAIL reset_addr: got %0h expected 0", charRamAddrB);
    else pass_cnt++;
    total_cnt++;
    if (fontAddr !== 11'd0) $display("FAIL reset_fontaddr: got %0h expected 0", fontAddr);
    else pass_cnt++;
    total_cnt++;
    if ({pixelR, pixelG, pixelB} !== 24'h0)
      $display("FAIL reset_pixels: got %0h expected 0", {pixelR, pixelG, pixelB});
    else pass_cnt++;
    resetn = 1'b1;
    step();
    exp_lv    = 1'b0;
    last_addr = 13'd0;
  endtask

  // mode 0: single trigger pulse; mode 1: trigger held for the whole window;
  // mode 2: a second trigger arrives while the first fetch is busy.
  // row < 0 means the line must not start a fetch.
  task automatic test_fetch(input logic [9:0] y, input int row, input int mode,
                            input string name);
    int          busy_cnt;
    int          rises;
    int          exp_busy;
    int          exp_rises;
    logic        prev;
    logic [12:0] exp_a;
    logic [12:0] exp_hold;
    busy_cnt = 0;
    rises    = 0;
    prev     = 1'b0;
    addr_q.delete();
    if (row >= 0) for (int i = 0; i < 80; i++) addr_q.push_back(13'(row * 80 + i));
    xOrd    = 10'd0;
    yOrd    = y;
    visible = 1'b0;
    step();
    xOrd = 10'd640;
    for (int c = 0; c < 150; c++) begin
      step();
      if (fetchBusy === 1'b1) begin
        busy_cnt++;
        if (!prev) rises++;
        if (addr_q.size() > 0) begin
          exp_a = addr_q.pop_front();
          total_cnt++;
          if (charRamAddrB !== exp_a)
            $display("FAIL %s_addr: got %0d expected %0d", name, charRamAddrB, exp_a);
          else pass_cnt++;
        end
      end
      prev = fetchBusy;
      if (c == 0 && mode != 1) xOrd = 10'd641;
      if (mode == 2 && c == 10) begin
        yOrd = y + 10'd16;
        xOrd = 10'd640;
      end
      if (mode == 2 && c == 11) xOrd = 10'd641;
    end
    exp_busy  = (row >= 0) ? 81 : 0;
    exp_rises = (row >= 0) ? 1 : 0;
    exp_hold  = (row >= 0) ? 13'(row * 80 + 79) : last_addr;
    total_cnt++;
    if (busy_cnt != exp_busy)
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
    else pass_cnt++;
    total_cnt++;
    if (rises != exp_rises)
      $display("FAIL %s_fetch_count: got %0d expected %0d", name, rises, exp_rises);
    else pass_cnt++;
    if (row >= 0) begin
      total_cnt++;
      if (addr_q.size() != 0)
        $display("FAIL %s_addr_left: got %0d expected 0", name, addr_q.size());
      else pass_cnt++;
    end
    total_cnt++;
    if (charRamAddrB !== exp_hold)
      $display("FAIL %s_addr_hold: got %0d expected %0d", name, charRamAddrB, exp_hold);
    else pass_cnt++;
    if (row >= 0) begin
      for (int i = 0; i < 80; i++) exp_line[i] = mem[row * 80 + i];
      exp_lv    = 1'b1;
      last_addr = exp_hold;
    end
  endtask

  // Drives n pixels starting at x0 on line y; vis_rand randomises visible.
  task automatic test_render(input logic [9:0] y, input int x0, input int n,
                             input int vis_rand, input string name);
    logic [23:0] exp_p;
    logic [11:0] exp_f;
    logic [9:0]  x;
    logic        v;
    int          col;
    pix_q.delete();
    fa_q.delete();
    yOrd = y;
    for (int k = 0; k < n + 2; k++) begin
      step();
      if (pix_q.size() >= 2) begin
        exp_p = pix_q.pop_front();
        total_cnt++;
        if ({pixelR, pixelG, pixelB} !== exp_p)
          $display("FAIL %s_pixel: got %0h expected %0h (k=%0d)", name,
                   {pixelR, pixelG, pixelB}, exp_p, k);
        else pass_cnt++;
      end
      if (fa_q.size() >= 1) begin
        exp_f = fa_q.pop_front();
        if (exp_f[11]) begin
          total_cnt++;
          if (fontAddr !== exp_f[10:0])
            $display("FAIL %s_fontaddr: got %0h expected %0h (k=%0d)", name,
                     fontAddr, exp_f[10:0], k);
          else pass_cnt++;
        end
      end
      if (k < n) begin
        x = 10'(x0 + k);
        v = (vis_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        x = 10'd0;
        v = 1'b0;
      end
      xOrd    = x;
      visible = v;
      pix_q.push_back(exp_pixel(x, y, v));
      col = int'(x) / 8;
      if (exp_lv && col < 80) fa_q.push_back({1'b1, exp_line[col], y[3:0]});
      else fa_q.push_back(12'h0);
    end
    visible = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    logic found;
    found   = 1'b0;
    xOrd    = 10'd0;
    yOrd    = 10'd63;
    visible = 1'b0;
    step();
    xOrd = 10'd640;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (c == 0) xOrd = 10'd641;
      if (fetchBusy === 1'b1 && charRamAddrB === 13'd360) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL midreset_reach_i40: got 0 expected 1");
    else pass_cnt++;
    resetn = 1'b0;
    step();
    total_cnt++;
    if (fetchBusy !== 1'b0) $display("FAIL midreset_busy: got %0h expected 0", fetchBusy);
    else pass_cnt++;
    total_cnt++;
    if (charRamAddrB !== 13'd0) $display("FAIL midreset_addr: got %0h expected 0", charRamAddrB);
    else pass_cnt++;
    resetn = 1'b1;
    exp_lv    = 1'b0;
    last_addr = 13'd0;
    step();
    total_cnt++;
    if (fetchBusy !== 1'b0) $display("FAIL midreset_no_resume: got %0h expected 0", fetchBusy);
    else pass_cnt++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 7'($urandom_range(0, 127));
    mem[64] = 7'd48;   // '0' at row 0, col 64
    mem[65] = 7'd65;   // 'A'
    mem[66] = 7'd32;   // space
    mem[67] = 7'd0;    // null
    mem[68] = 7'd65;
    exp_lv    = 1'b0;
    last_addr = 13'd0;

    test_reset();
    test_fetch(10'd524, 0, 0, "fetch_row0");
    test_render(10'd3, 512, 48, 0, "glyph_zero");
    test_render(10'd3, 0, 720, 1, "row0_sweep");
    test_fetch(10'd15, 1, 0, "fetch_row1");
    test_render(10'd9, 0, 700, 1, "row1_sweep");
    test_fetch(10'd479, -1, 0, "no_fetch_last_row");
    test_fetch(10'd31, 2, 1, "once_per_line");
    test_fetch(10'd47, 3, 2, "back_to_back");
    test_render(10'd50, 0, 640, 1, "row3_sweep");
    test_reset_mid_fetch();
    test_render(10'd70, 0, 300, 0, "after_reset_clear");
    test_fetch(10'd63, 4, 0, "fetch_row4");
    test_render(10'd70, 0, 640, 1, "row4_sweep");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/char_ram_line_reader.md
CHAR_RAM_LINE_READER -- requirements
Module: char_ram_line_reader

Interface
REQ-001 SHALL have parameters: COLS, default 80, text columns per row; ROWS, default 30, text rows; H_ACTIVE, default 640, first blanking xOrd; V_TOTAL, default 525, lines per frame.
REQ-002 SHALL have ports, clock and reset first:
- clock50MHz  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- xOrd  in  10  pixel column
- yOrd  in  10  pixel line
- visible  in  1  active video
- charRamAddrB  out  13  character RAM read address
- charRamDataRdB  in  7  character RAM read data
- fontAddr  out  11  font ROM address, {code, glyphRow}
- fontRowData  in  8  font ROM row, bit 7 = leftmost pixel
- pixelR  out  8  text red
- pixelG  out  8  text green
- pixelB  out  8  text blue
- fetchBusy  out  1  line fetch in progress
REQ-003 SHALL treat reset as resetn, synchronous, active-low, on clock clock50MHz.

Function
REQ-004 SHALL be the read-side consumer of the character RAM; address = row*COLS + col; cells are 8x16 pixels.
REQ-005 SHALL assume both character RAM port B and font ROM have 1-cycle synchronous read latency.
REQ-006 SHALL use FSM states IDLE, FETCH and DRAIN.
REQ-007 IDLE->FETCH SHALL occur when xOrd==H_ACTIVE and either yOrd[3:0]==15 with yOrd<16*ROWS-1 (target row = (yOrd+1)>>4) or yOrd==V_TOTAL-1 (target row 0).
REQ-008 No fetch SHALL occur for yOrd==16*ROWS-1; the trigger SHALL fire at most once per line.
REQ-009 In FETCH, charRamAddrB SHALL present row*COLS+i for i=0..COLS-1 on consecutive cycles; FETCH->DRAIN after i=COLS-1.
REQ-010 Each returned byte SHALL be written to lineBuf[i] one cycle after its address.
REQ-011 DRAIN SHALL last one cycle, capture the last byte, set lineValid, then return to IDLE.
REQ-012 A fetch SHALL take COLS+1 cycles; fetchBusy SHALL be 1 exactly in FETCH and DRAIN.
REQ-013 A trigger while fetchBusy SHALL be ignored.
REQ-014 charRamAddrB SHALL hold its last value outside FETCH.
REQ-015 Render stage 1 SHALL register code=lineBuf[xOrd[9:3]], bitSel=xOrd[2:0] and visible.
REQ-016 Stage 1 SHALL drive fontAddr={code, yOrd[3:0]}.
REQ-017 Stage 2 SHALL output fontRowData[7-bitSel]; pixel latency SHALL be 2 cycles from xOrd/yOrd/visible.
REQ-018 A pixel SHALL be 8'hFF on all channels when visible, lineValid, code not 7'd0/7'd32 and the font bit is 1; otherwise 0. Zero means transparent to the downstream arbiter.
REQ-019 xOrd[9:3]>=COLS SHALL render transparent.

Reset
REQ-020 Reset SHALL force state=IDLE, fetchBusy=0, charRamAddrB=0, fontAddr=0, pixelR/G/B=0, lineValid=0 and clear pipeline valids.
REQ-021 lineBuf SHALL not be reset.
REQ-022 Reset mid-fetch SHALL abort the fetch; pixels SHALL stay transparent until the next completed fetch.

Configuration
REQ-023 With CHAR_RAM_READER_BGBOX_EN defined: visible, valid, non-blank cells SHALL output 8'h20 on each channel where the glyph bit is 0.
REQ-024 Without CHAR_RAM_READER_BGBOX_EN: those pixels SHALL be 0, transparent.

Verification
REQ-025 Reset, then xOrd=640, yOrd=524 -> fetchBusy high 81 cycles; charRamAddrB 0..79; lineValid set.
REQ-026 yOrd=15, xOrd=640 -> addresses 80..159.
REQ-027 yOrd=479, xOrd=640 -> no fetch; fetchBusy stays 0.
REQ-028 RAM[64]=7'd48 ('0'), row 0 fetched, xOrd=512..519, yOrd=3, fontRowData=8'b00111100 -> after 2-cycle latency, pixels 0,0,FF,FF,FF,FF,0,0; fontAddr={7'd48,4'd3}.
REQ-029 resetn low at fetch i=40 -> state IDLE, fetchBusy 0, all pixels 0 until the next fetch completes.
REQ-030 Cell code 7'd65 with glyph bit 0 -> 8'h20 with CHAR_RAM_READER_BGBOX_EN, 0 without; code 7'd32 -> 0 in both builds.
